uart_tx_feeder: RTL

//  Buffers bytes from a host write port in a FIFO and launches them one at a time into uart_tx.

---
 rtl/uart_tx_feeder.sv | 137 +++++++++++++
 1 files changed

// File: rtl/uart_tx_feeder.sv
// Byte FIFO that feeds uart_tx one word at a time: pulses tx_start, then waits for tx_busy to
// rise and fall before the next launch. Busy-handshake timeouts and dropped writes are sticky.
module uart_tx_feeder #(
    parameter int unsigned DW           = 8,
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned BUSY_TIMEOUT = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     wr_en_i,
    input  logic [DW-1:0]            wr_data_i,
    input  logic                     clr_flags_i,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o,
    output logic                     start_err_o,
    output logic                     tx_start,
    output logic [DW-1:0]            tx_data,
    input  logic                     tx_busy
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = $clog2(BUSY_TIMEOUT) + 1;
    // The LAUNCH cycle already counts as one timeout cycle, so WAIT_BUSY spends TIMEOUT-1.
    localparam logic [TW-1:0] TimerLast = TW'(BUSY_TIMEOUT - 2);

    typedef enum logic [1:0] {StIdle, StLaunch, StWaitBusy, StWaitDone} state_e;

    state_e          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            full_q, full_d, empty_q, empty_d;
    logic            ovf_q, ovf_d, err_q, err_d;
    logic            tx_start_q, tx_start_d;
    logic [DW-1:0]   tx_data_q, tx_data_d;
    logic [DW-1:0]   mem_q [DEPTH];
    logic            push, launch, err_set;

    assign push = wr_en_i && !full_q;

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        tx_start_d = 1'b0;
        launch     = 1'b0;
        err_set    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!empty_q && !tx_busy) begin
                    launch     = 1'b1;
                    tx_start_d = 1'b1;
                    state_d    = StLaunch;
                end
            end
            StLaunch: begin
                timer_d = '0;
                state_d = tx_busy ? StWaitDone : StWaitBusy;
            end
            StWaitBusy: begin
                if (tx_busy) begin
                    state_d = StWaitDone;
                end else if (timer_q == TimerLast) begin
                    err_set = 1'b1;
                    state_d = StIdle;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            StWaitDone: begin
                if (!tx_busy) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        wr_ptr_d  = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d  = launch ? rd_ptr_q + AW'(1) : rd_ptr_q;
        tx_data_d = launch ? mem_q[rd_ptr_q] : tx_data_q;
        count_d   = count_q;
        if (push && !launch) begin
            count_d = count_q + CW'(1);
        end else if (!push && launch) begin
            count_d = count_q - CW'(1);
        end
        full_d  = (count_d == CW'(DEPTH));
        empty_d = (count_d == '0);
        // A set event in the same cycle as a clear keeps the flag.
        ovf_d = (wr_en_i && full_q) ? 1'b1 : (clr_flags_i ? 1'b0 : ovf_q);
        err_d = err_set ? 1'b1 : (clr_flags_i ? 1'b0 : err_q);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= StIdle;
            timer_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            ovf_q      <= 1'b0;
            err_q      <= 1'b0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            ovf_q      <= ovf_d;
            err_q      <= err_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
        end
    end

    // Storage needs no reset: pointers and count alone define which entries are valid.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign full_o      = full_q;
    assign empty_o     = empty_q;
    assign count_o     = count_q;
    assign overflow_o  = ovf_q;
    assign start_err_o = err_q;
    assign tx_start    = tx_start_q;
    assign tx_data     = tx_data_q;

endmodule
